// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the 8-bit PC datapath.
// It fetches over req/ack, decodes branch/jump/halt, issues ALU ops over valid/ready, and strobes the PC load.
module pc_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic       exec_valid,
  input  logic       exec_ready,
  input  logic       zero_flag,
  output logic       pc_en,
  output logic [7:0] pc_control,
  output logic [7:0] jump_offset,
  output logic       busy,
  output logic       halted,
  output logic       fetch_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [7:0] TIMEOUT_LIM = 8'(FETCH_TIMEOUT);

  logic [2:0] state;
  logic [7:0] timeout_cnt;
  logic [7:0] timeout_inc;
  logic       taken;
  logic       armed;

  assign timeout_inc = timeout_cnt + 8'd1;

  // armed stays low for the first edge after reset release, so a start
  // coincident with deassertion is not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr       <= '0;
      timeout_cnt <= '0;
      taken       <= 1'b0;
      fetch_err   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start && armed) state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            timeout_cnt <= '0;
            state       <= S_DECODE;
          end else begin
            timeout_cnt <= timeout_inc;
            if (timeout_inc == TIMEOUT_LIM) begin
              fetch_err <= 1'b1;
              state     <= S_HALT;
            end
          end
        end
        S_DECODE: begin
          case (instr[7:6])
            2'b00: begin
              taken <= 1'b0;
              state <= S_EXEC;
            end
            2'b01: begin
              taken <= zero_flag;
              state <= S_UPDATE;
            end
            2'b10: begin
              taken <= 1'b1;
              state <= S_UPDATE;
            end
            default: begin
              taken <= 1'b0;
              state <= (instr == 8'hFF) ? S_HALT : S_UPDATE;
            end
          endcase
        end
        S_EXEC: begin
          if (exec_ready) state <= S_UPDATE;
        end
        S_UPDATE: state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign exec_valid  = (state == S_EXEC);
  assign pc_en       = (state == S_UPDATE);
  assign pc_control  = (pc_en && taken) ? 8'hFF : 8'h00;
  assign jump_offset = (pc_en && taken) ? {{2{instr[5]}}, instr[5:0]} : 8'h00;
  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer, with a bench-side PC register model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic       exec_valid;
  logic       exec_ready;
  logic       zero_flag;
  logic       pc_en;
  logic [7:0] pc_control;
  logic [7:0] jump_offset;
  logic       busy;
  logic       halted;
  logic       fetch_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  pc;

  pc_sequencer #(.FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .exec_valid(exec_valid), .exec_ready(exec_ready),
    .zero_flag(zero_flag), .pc_en(pc_en), .pc_control(pc_control),
    .jump_offset(jump_offset), .busy(busy), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply the PC datapath when the load strobe is seen.
  task automatic pc_apply();
    if (pc_en) pc = pc + 8'd1 + (pc_control & jump_offset);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},  imem_req,   1'b0);
    check({tag, "_ev"},   exec_valid, 1'b0);
    check({tag, "_pcen"}, pc_en,      1'b0);
    check({tag, "_ctl"},  pc_control, 8'h00);
    check({tag, "_off"},  jump_offset, 8'h00);
    check({tag, "_busy"}, busy,       1'b0);
    check({tag, "_halt"}, halted,     1'b0);
    check({tag, "_ferr"}, fetch_err,  1'b0);
  endtask

  task automatic do_reset();
    start = 1'b0; imem_ack = 1'b0; exec_ready = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in FETCH; runs one non-ALU instruction through UPDATE back to FETCH.
  task automatic run_flow(input string tag, input logic [7:0] data, input logic zf,
                          input logic [7:0] exp_ctl, input logic [7:0] exp_off,
                          input logic [7:0] exp_pc);
    zero_flag = ~zf;
    imem_data = data; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    zero_flag = zf;
    check({tag, "_dec_pcen"}, pc_en, 1'b0);
    check({tag, "_dec_ctl"}, pc_control, 8'h00);
    step();
    zero_flag = ~zf;
    #1;
    check({tag, "_pcen"}, pc_en, 1'b1);
    check({tag, "_ctl"}, pc_control, exp_ctl);
    check({tag, "_off"}, jump_offset, exp_off);
    pc_apply();
    check({tag, "_pc"}, pc, exp_pc);
    step();
    check({tag, "_refetch"}, imem_req, 1'b1);
    check({tag, "_pcen_drop"}, pc_en, 1'b0);
  endtask

  initial begin
    int unsigned vcnt;
    int unsigned fcnt;
    rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
    exec_ready = 1'b0; zero_flag = 1'b0; pc = '0;

    // Reset and IDLE
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst");
    check("rst_instr", instr, 8'h00);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_req", imem_req, 1'b0);
    end
    check_idle_outputs("idle");
    kick();
    check("start_req", imem_req, 1'b1);
    check("start_busy", busy, 1'b1);

    // ALU op, exec_ready three cycles late
    pc = 8'h00;
    imem_data = 8'h12; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("alu_instr", instr, 8'h12);
    check("alu_dec_req", imem_req, 1'b0);
    step();
    vcnt = 0;
    repeat (3) begin
      if (exec_valid) vcnt++;
      check("alu_wait_pcen", pc_en, 1'b0);
      step();
    end
    if (exec_valid) vcnt++;
    exec_ready = 1'b1;
    step();
    exec_ready = 1'b0;
    check("alu_valid_cycles", vcnt, 4);
    check("alu_valid_drop", exec_valid, 1'b0);
    check("alu_pcen", pc_en, 1'b1);
    check("alu_ctl", pc_control, 8'h00);
    check("alu_off", jump_offset, 8'h00);
    pc_apply();
    check("alu_pc", pc, 8'h01);
    step();
    check("alu_refetch", imem_req, 1'b1);
    check("alu_pcen_drop", pc_en, 1'b0);

    // Branch taken / not taken, jump wrap, NOP
    pc = 8'h05;
    run_flow("br_tk", 8'h7E, 1'b1, 8'hFF, 8'hFE, 8'h04);
    pc = 8'h05;
    run_flow("br_nt", 8'h7E, 1'b0, 8'h00, 8'h00, 8'h06);
    pc = 8'hF0;
    run_flow("jmp", 8'h9F, 1'b0, 8'hFF, 8'h1F, 8'h10);
    pc = 8'h20;
    run_flow("nop", 8'hC5, 1'b1, 8'h00, 8'h00, 8'h21);

    // Halt
    imem_data = 8'hFF; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("halt_dec_pcen", pc_en, 1'b0);
    step();
    check("halt_halted", halted, 1'b1);
    check("halt_busy", busy, 1'b0);
    check("halt_pcen", pc_en, 1'b0);
    check("halt_ferr", fetch_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      kick();
      check("halt_start_ign", {halted, imem_req, pc_en}, 3'b100);
    end
    do_reset();
    check_idle_outputs("halt_rst");

    // start coincident with reset release is ignored
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1; start = 1'b1;
    step();
    check("rel_start_ign", imem_req, 1'b0);
    step();
    start = 1'b0;
    check("rel_start_next", imem_req, 1'b1);

    // Fetch timeout
    fcnt = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      if (imem_req) fcnt++;
      step();
    end
    check("to_cycles", fcnt, 15);
    check("to_halted", halted, 1'b1);
    check("to_ferr", fetch_err, 1'b1);
    check("to_busy", busy, 1'b0);
    do_reset();
    check("to_ferr_clr", fetch_err, 1'b0);

    // Reset during EXEC with exec_ready pending
    kick();
    imem_data = 8'h05; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    check("mid_ev", exec_valid, 1'b1);
    exec_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_ev_off", exec_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_pcen", pc_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_pcen", pc_en, 1'b0);
    end
    exec_ready = 1'b0;
    rst_n = 1'b1;
    step();
    check_idle_outputs("mid_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
